ysyx_040750_gpr_sb: RTL and testbench

//  Parametrised multi-port integer register file with integrated scoreboard, next-gen GPR for the pipelined core.
//  NR async read ports and NW sync write ports; x0 is hardwired to zero.

---
 rtl/ysyx_040750_rf_pkg.sv | 19 +
 rtl/ysyx_040750_sb_cnt.sv | 43 ++++
 rtl/ysyx_040750_gpr_sb.sv | 146 ++++++++++++++
 tb/tb_ysyx_040750_gpr_sb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040750_rf_pkg.sv
// Shared constants, types and helpers for the GPR file and its scoreboard.
package ysyx_040750_rf_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Number of set bits; used to count write ports retiring into one register.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ysyx_040750_sb_cnt.sv
// Pending-write counter for one architectural register: counts issued but not
// yet written-back producers and flags writebacks nobody was waiting for.
module ysyx_040750_sb_cnt #(
    parameter int CNT_W = 2,
    parameter int DW    = 1
) (
    input  logic             I_sys_clk,
    input  logic             I_rst,
    input  logic             inc_i,
    input  logic [DW-1:0]    dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o,
    output logic             sat_o,
    output logic             underflow_o
);

    localparam int SW = CNT_W + DW;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SW-1:0]    sum;

    // Issue is refused at saturation, so sum - dec always fits back in CNT_W.
    always_comb begin
        sum         = SW'(cnt_q) + SW'(inc_i);
        underflow_o = SW'(dec_i) > sum;
        cnt_d       = underflow_o ? '0 : CNT_W'(sum - SW'(dec_i));
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy ignores this cycle's issue so the read side never depends on issue.
    assign busy_o = SW'(cnt_q) > SW'(dec_i);
    assign sat_o  = (cnt_q == '1);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ysyx_040750_gpr_sb.sv
// Multi-port integer register file (x0 = 0) with per-register pending-write
// scoreboard used by ID to stall on RAW hazards.
module ysyx_040750_gpr_sb
    import ysyx_040750_rf_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1
) (
    input  logic                 I_sys_clk,
    input  logic                 I_rst,
    input  logic [NR*REG_AW-1:0] I_rs_addr,
    output logic [NR*XLEN-1:0]   O_rs_data,
    output logic [NR-1:0]        O_rs_busy,
    input  logic [NW-1:0]        I_wen,
    input  logic [NW*REG_AW-1:0] I_rd_addr,
    input  logic [NW*XLEN-1:0]   I_wr_data,
    input  logic                 I_iss_valid,
    input  logic [REG_AW-1:0]    I_iss_rd,
    output logic                 O_iss_ready,
    output logic                 O_err
);

    localparam int DW = $clog2(NW + 1);

    logic [XLEN-1:0]  gpr_q   [NREG];
    logic [NW-1:0]    hit_d   [NREG];
    logic [XLEN-1:0]  wdata_d [NREG];
    logic [DW-1:0]    dec_d   [NREG];
    logic [CNT_W-1:0] cnt_a   [NREG];
    logic             busy_a  [NREG];
    logic             sat_a   [NREG];
    logic             unf_a   [NREG];
    logic             iss_fire;
    logic             any_unf;
    logic             err_q;
    logic             err_d;

    // Per-register write decode; the later (higher-index) port wins the data.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            hit_d[i]   = '0;
            wdata_d[i] = '0;
            for (int k = 0; k < NW; k++) begin
                if (i != 0 && I_wen[k] &&
                    I_rd_addr[k*REG_AW +: REG_AW] == reg_addr_t'(i)) begin
                    hit_d[i][k] = 1'b1;
                    wdata_d[i]  = I_wr_data[k*XLEN +: XLEN];
                end
            end
            dec_d[i] = DW'(popcount(32'(hit_d[i])));
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (|hit_d[i]) begin
                    gpr_q[i] <= wdata_d[i];
                end
            end
        end
    end

    assign iss_fire = I_iss_valid & O_iss_ready;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_x0
            assign cnt_a[gi]  = '0;
            assign busy_a[gi] = 1'b0;
            assign sat_a[gi]  = 1'b0;
            assign unf_a[gi]  = 1'b0;
        end else begin : g_cnt
            logic inc;
            assign inc = iss_fire && (I_iss_rd == reg_addr_t'(gi));

            ysyx_040750_sb_cnt #(
                .CNT_W(CNT_W),
                .DW   (DW)
            ) u_cnt (
                .I_sys_clk  (I_sys_clk),
                .I_rst      (I_rst),
                .inc_i      (inc),
                .dec_i      (dec_d[gi]),
                .cnt_o      (cnt_a[gi]),
                .busy_o     (busy_a[gi]),
                .sat_o      (sat_a[gi]),
                .underflow_o(unf_a[gi])
            );
        end
    end

    assign O_iss_ready = ~I_rst & ((I_iss_rd == '0) | ~sat_a[I_iss_rd]);

    always_comb begin
        any_unf = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            any_unf = any_unf | unf_a[i];
        end
        err_d = err_q | any_unf;
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign O_err = err_q;

    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = I_rs_addr[gi*REG_AW +: REG_AW];

        always_comb begin
            data = gpr_q[addr];
            if (BYPASS != 0) begin
                for (int k = 0; k < NW; k++) begin
                    if (I_wen[k] && I_rd_addr[k*REG_AW +: REG_AW] == addr) begin
                        data = I_wr_data[k*XLEN +: XLEN];
                    end
                end
            end
            busy = (BYPASS != 0) ? busy_a[addr] : (cnt_a[addr] != '0);
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign O_rs_data[gi*XLEN +: XLEN] = data;
        assign O_rs_busy[gi]              = busy;
    end

endmodule

// File: tb/tb_ysyx_040750_gpr_sb.sv
// Scoreboard bench for the GPR file: expectations are queued as each cycle is
// driven and compared against the DUT outputs once that cycle has settled.
module tb_ysyx_040750_gpr_sb;

    localparam int XLEN = 64;
    localparam int NR   = 2;
    localparam int NW   = 2;

    localparam int SEL_D0  = 0;
    localparam int SEL_D1  = 1;
    localparam int SEL_B0  = 2;
    localparam int SEL_B1  = 3;
    localparam int SEL_RDY = 4;
    localparam int SEL_ERR = 5;

    logic               clk;
    logic               rst;
    logic [NR*5-1:0]    rs_addr;
    logic [NR*XLEN-1:0] rs_data;
    logic [NR-1:0]      rs_busy;
    logic [NW-1:0]      wen;
    logic [NW*5-1:0]    rd_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic               iss_valid;
    logic [4:0]         iss_rd;
    logic               iss_ready;
    logic               err;

    int          n_pass;
    int          n_total;
    string       tag_q [$];
    int          sel_q [$];
    logic [63:0] exp_q [$];

    ysyx_040750_gpr_sb #(
        .XLEN  (XLEN),
        .NR    (NR),
        .NW    (NW),
        .CNT_W (2),
        .BYPASS(1)
    ) dut (
        .I_sys_clk  (clk),
        .I_rst      (rst),
        .I_rs_addr  (rs_addr),
        .O_rs_data  (rs_data),
        .O_rs_busy  (rs_busy),
        .I_wen      (wen),
        .I_rd_addr  (rd_addr),
        .I_wr_data  (wr_data),
        .I_iss_valid(iss_valid),
        .I_iss_rd   (iss_rd),
        .O_iss_ready(iss_ready),
        .O_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_D0:  return rs_data[0 +: XLEN];
            SEL_D1:  return rs_data[XLEN +: XLEN];
            SEL_B0:  return {63'd0, rs_busy[0]};
            SEL_B1:  return {63'd0, rs_busy[1]};
            SEL_RDY: return {63'd0, iss_ready};
            default: return {63'd0, err};
        endcase
    endfunction

    task automatic expect_push(input string tag, input int sel, input logic [63:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic sb_drain();
        string       t;
        int          s;
        logic [63:0] e;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            chk_val(t, observe(s), e);
        end
    endtask

    task automatic idle();
        rs_addr   = '0;
        wen       = '0;
        rd_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        rs_addr[k*5 +: 5] = a;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [63:0] d);
        wen[k]                = 1'b1;
        rd_addr[k*5 +: 5]     = a;
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_rd    = a;
    endtask

    // Settle, score this cycle, then advance one clock and clear stimulus.
    task automatic cyc();
        #1;
        sb_drain();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // reset held: issue refused
        issue(5'd1);
        expect_push("rst_ready", SEL_RDY, 64'd0);
        cyc();
        rst = 1'b0;

        // post-reset state; issue x5
        rd(0, 5'd0); rd(1, 5'd5); issue(5'd5);
        expect_push("rst_err", SEL_ERR, 64'd0);
        expect_push("rst_d1", SEL_D1, 64'd0);
        expect_push("rst_b1", SEL_B1, 64'd0);
        expect_push("rst_b0_x0", SEL_B0, 64'd0);
        expect_push("iss_x5_ready", SEL_RDY, 64'd1);
        cyc();

        // test 1: write x5 then read it
        wr(0, 5'd5, 64'hDEAD_BEEF); rd(0, 5'd5);
        expect_push("t1_byp_data", SEL_D0, 64'hDEAD_BEEF);
        expect_push("t1_byp_busy", SEL_B0, 64'd0);
        cyc();
        rd(0, 5'd5);
        expect_push("t1_data", SEL_D0, 64'hDEAD_BEEF);
        expect_push("t1_busy", SEL_B0, 64'd0);
        expect_push("t1_err", SEL_ERR, 64'd0);
        cyc();

        // test 2: x0 is never written
        wr(0, 5'd0, 64'h1234); rd(0, 5'd0);
        expect_push("t2_x0_during", SEL_D0, 64'd0);
        expect_push("t2_x0_busy", SEL_B0, 64'd0);
        cyc();
        rd(0, 5'd0); rd(1, 5'd5);
        expect_push("t2_x0_after", SEL_D0, 64'd0);
        expect_push("t2_x5_kept", SEL_D1, 64'hDEAD_BEEF);
        expect_push("t2_err", SEL_ERR, 64'd0);
        cyc();

        // test 3: two ports write x7, higher port wins
        for (int n = 0; n < 2; n++) begin
            issue(5'd7);
            expect_push("t3_iss_ready", SEL_RDY, 64'd1);
            cyc();
        end
        wr(0, 5'd7, 64'h11); wr(1, 5'd7, 64'h22); rd(1, 5'd7);
        expect_push("t3_byp_data", SEL_D1, 64'h22);
        expect_push("t3_byp_busy", SEL_B1, 64'd0);
        cyc();
        rd(0, 5'd7); rd(1, 5'd7);
        expect_push("t3_after_p0", SEL_D0, 64'h22);
        expect_push("t3_after_p1", SEL_D1, 64'h22);
        expect_push("t3_err", SEL_ERR, 64'd0);
        cyc();

        // test 4: two producers on x3, then saturation
        for (int n = 0; n < 2; n++) begin
            issue(5'd3);
            expect_push("t4_iss_ready", SEL_RDY, 64'd1);
            cyc();
        end
        wr(0, 5'd3, 64'h33); rd(0, 5'd3);
        expect_push("t4_wb1_busy", SEL_B0, 64'd1);
        expect_push("t4_wb1_data", SEL_D0, 64'h33);
        cyc();
        rd(0, 5'd3);
        expect_push("t4_hold_busy", SEL_B0, 64'd1);
        cyc();
        wr(1, 5'd3, 64'h34); rd(0, 5'd3);
        expect_push("t4_wb2_busy", SEL_B0, 64'd0);
        cyc();
        rd(0, 5'd3);
        expect_push("t4_idle_busy", SEL_B0, 64'd0);
        expect_push("t4_idle_data", SEL_D0, 64'h34);
        expect_push("t4_err", SEL_ERR, 64'd0);
        cyc();
        for (int n = 0; n < 3; n++) begin
            issue(5'd3); rd(1, 5'd3);
            expect_push("t4_fill_ready", SEL_RDY, 64'd1);
            if (n > 0) expect_push("t4_fill_busy", SEL_B1, 64'd1);
            cyc();
        end
        issue(5'd3);
        expect_push("t4_sat_ready", SEL_RDY, 64'd0);
        cyc();
        issue(5'd3);
        expect_push("t4_sat_hold", SEL_RDY, 64'd0);
        cyc();
        issue(5'd0);
        expect_push("t4_x0_ready", SEL_RDY, 64'd1);
        cyc();

        // test 5: net issue/writeback, then stray writeback sets err
        issue(5'd9);
        expect_push("t5_iss_ready", SEL_RDY, 64'd1);
        cyc();
        issue(5'd9); wr(0, 5'd9, 64'h99); rd(0, 5'd9);
        expect_push("t5_same_ready", SEL_RDY, 64'd1);
        expect_push("t5_comb_busy", SEL_B0, 64'd0);
        cyc();
        rd(0, 5'd9);
        expect_push("t5_net_busy", SEL_B0, 64'd1);
        expect_push("t5_net_data", SEL_D0, 64'h99);
        expect_push("t5_err_clean", SEL_ERR, 64'd0);
        cyc();
        wr(0, 5'd10, 64'hAA);
        expect_push("t5_err_pre", SEL_ERR, 64'd0);
        cyc();
        expect_push("t5_err_set", SEL_ERR, 64'd1);
        cyc();
        expect_push("t5_err_sticky", SEL_ERR, 64'd1);
        cyc();

        // test 6: reset mid-stream
        for (int n = 0; n < 2; n++) begin
            issue(5'd4);
            cyc();
        end
        rd(0, 5'd4);
        expect_push("t6_busy_pre", SEL_B0, 64'd1);
        cyc();
        rst = 1'b1;
        wr(0, 5'd6, 64'h66); issue(5'd4);
        expect_push("t6_rst_ready", SEL_RDY, 64'd0);
        cyc();
        rst = 1'b0;
        rd(0, 5'd4); rd(1, 5'd6); iss_rd = 5'd4;
        expect_push("t6_x4_data", SEL_D0, 64'd0);
        expect_push("t6_x4_busy", SEL_B0, 64'd0);
        expect_push("t6_x6_data", SEL_D1, 64'd0);
        expect_push("t6_x6_busy", SEL_B1, 64'd0);
        expect_push("t6_ready", SEL_RDY, 64'd1);
        expect_push("t6_err", SEL_ERR, 64'd0);
        cyc();
        rd(0, 5'd7); rd(1, 5'd3); iss_rd = 5'd3;
        expect_push("t6_x7_data", SEL_D0, 64'd0);
        expect_push("t6_x3_busy", SEL_B1, 64'd0);
        expect_push("t6_x3_ready", SEL_RDY, 64'd1);
        cyc();

        chk_val("sb_left", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
